// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned WAIT_W   = 4;
    localparam int unsigned ERR_W    = 3;
    localparam int unsigned STAT_W   = 16;
    localparam int unsigned ERRCNT_W = 8;

    // Bit positions inside the captured error-cause vector.
    localparam int unsigned ERR_ALIGN    = 0;
    localparam int unsigned ERR_RANGE    = 1;
    localparam int unsigned ERR_CONFLICT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ERR_W-1:0]  cause;
        logic [WORD_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read at the same index.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target with wait states, one-cycle ready pulse and error checks.
// Optional access/error counters are compiled in with DMEM_STATS_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [WORD_W-1:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cs_i,
    input  logic                r_i,
    input  logic                w_i,
    input  logic [WORD_W-1:0]   addr_i,
    input  logic [WORD_W-1:0]   wdata_i,
    output logic [WORD_W-1:0]   rdata_o,
    output logic                ready_o,
    output logic                err_o,
    output logic                busy_o
`ifdef DMEM_STATS_EN
    ,
    output logic [STAT_W-1:0]   rd_count_o,
    output logic [STAT_W-1:0]   wr_count_o,
    output logic [ERRCNT_W-1:0] err_count_o
`endif
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned SPAN_W = WORD_W + 1;
    localparam logic [SPAN_W-1:0] SPAN = SPAN_W'(DEPTH_WORDS) << 2;

    dmem_state_t       state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    dmem_req_t         req_q, req_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic              accept_c;
    logic              we_c;
    logic [WORD_W-1:0] offs_c;
    logic [ERR_W-1:0]  cause_c;
    logic [WORD_W-1:0] arr_rdata;

    // Request decode and capture; the array is addressed with the index being captured.
    always_comb begin
        accept_c = (state_q == IDLE) & cs_i & (r_i | w_i);
        offs_c   = addr_i - ADDR_BASE;
        cause_c  = '0;
        cause_c[ERR_ALIGN]    = |addr_i[1:0];
        cause_c[ERR_RANGE]    = ({1'b0, offs_c} >= SPAN);
        cause_c[ERR_CONFLICT] = r_i & w_i;
        req_d    = req_q;
        idx_d    = idx_q;
        if (accept_c) begin
            req_d.rd    = r_i;
            req_d.wr    = w_i;
            req_d.cause = cause_c;
            req_d.wdata = wdata_i;
            idx_d       = offs_c[IDX_W+1:2];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        we_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                we_c    = req_q.wr & ~(|req_q.cause);
            end
            default: state_d = IDLE;
        endcase
        // Response outputs are registered on the edge that enters RESP.
        if ((state_d == RESP) && (state_q != RESP)) begin
            ready_d = 1'b1;
            err_d   = |req_d.cause;
            if (|req_d.cause) begin
                rdata_d = '0;
            end else if (req_d.rd) begin
                rdata_d = arr_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (we_c),
        .idx_i   (idx_d),
        .wdata_i (req_q.wdata),
        .rdata_o (arr_rdata)
    );

    assign rdata_o = rdata_q;
    assign ready_o = ready_q;
    assign err_o   = err_q;
    // Busy covers the acceptance cycle itself through the response cycle.
    assign busy_o  = rst_ni & ((state_q != IDLE) | accept_c);

`ifdef DMEM_STATS_EN
    logic [STAT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [STAT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating completion counters, updated as the response cycle ends.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (state_q == RESP) begin
            if (|req_q.cause) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
            end else if (req_q.rd) begin
                if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + STAT_W'(1);
            end else begin
                if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rd_count_o  = rd_cnt_q;
    assign wr_count_o  = wr_cnt_q;
    assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with WAIT_CYCLES=0, one with WAIT_CYCLES=1.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs    [2];
    logic        r     [2];
    logic        w     [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];
    logic        busy  [2];
`ifdef DMEM_STATS_EN
    logic [15:0] rdc [2];
    logic [15:0] wrc [2];
    logic [7:0]  erc [2];
`endif

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mdl     [2][DEPTH];
    logic [31:0] last_rd [2];
    int          n_rd [2];
    int          n_wr [2];
    int          n_er [2];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_BASE(BASE)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cs_i(cs[0]), .r_i(r[0]), .w_i(w[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
        .ready_o(ready[0]), .err_o(err[0]), .busy_o(busy[0])
`ifdef DMEM_STATS_EN
        , .rd_count_o(rdc[0]), .wr_count_o(wrc[0]), .err_count_o(erc[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .ADDR_BASE(BASE)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cs_i(cs[1]), .r_i(r[1]), .w_i(w[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
        .ready_o(ready[1]), .err_o(err[1]), .busy_o(busy[1])
`ifdef DMEM_STATS_EN
        , .rd_count_o(rdc[1]), .wr_count_o(wrc[1]), .err_count_o(erc[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Every ready pulse must match the oldest queued expectation of its instance.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            int   sz;
            sz = (k == 0) ? q0.size() : q1.size();
            if (ready[k] === 1'b1) begin
                check("resp_expected", 32'(sz != 0), 32'd1);
                if (sz != 0) begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check("resp_err", 32'(err[k]), 32'(e.err));
                    check("resp_rdata", rdata[k], e.rdata);
                end
            end else begin
                check("err_without_ready", 32'(err[k]), 32'd0);
            end
        end
    end

    task automatic access(input int k, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input logic toggle);
        exp_t        e;
        logic        bad;
        logic [31:0] offs;
        int          lat;
        int          bc;
        int          wc;
        logic        seen;
        wc   = (k == 0) ? 0 : 1;
        offs = a - BASE;
        bad  = (a[1:0] != 2'b00) || (offs >= DEPTH * 4) || (rd && wr);
        if (bad)     last_rd[k] = 32'h0;
        else if (rd) last_rd[k] = mdl[k][offs[5:2]];
        if (!bad && wr) mdl[k][offs[5:2]] = d;
        if (bad)     n_er[k]++;
        else if (rd) n_rd[k]++;
        else         n_wr[k]++;
        e.err   = bad;
        e.rdata = last_rd[k];
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);

        @(negedge clk);
        cs[k] = 1'b1; r[k] = rd; w[k] = wr; addr[k] = a; wdata[k] = d;
        #1 bc = int'(busy[k]);
        @(posedge clk);
        #1;
        if (toggle) begin
            addr[k]  = a ^ 32'h4;
            wdata[k] = ~d;
        end else begin
            cs[k] = 1'b0; r[k] = 1'b0; w[k] = 1'b0;
            addr[k] = $urandom; wdata[k] = $urandom;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy[k] === 1'b1) bc++;
            if (ready[k] === 1'b1) seen = 1'b1;
        end
        cs[k] = 1'b0; r[k] = 1'b0; w[k] = 1'b0;
        check("ready_latency", 32'(lat), 32'(wc + 1));
        check("busy_cycles", 32'(bc), 32'(wc + 2));
        @(negedge clk);
        check("busy_after_resp", 32'(busy[k]), 32'd0);
        check("rdata_hold", rdata[k], last_rd[k]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cs[k] = 1'b0; r[k] = 1'b0; w[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
            last_rd[k] = '0; n_rd[k] = 0; n_wr[k] = 0; n_er[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_ready", 32'(ready[k]), 32'd0);
            check("reset_err", 32'(err[k]), 32'd0);
            check("reset_busy", 32'(busy[k]), 32'd0);
            check("reset_rdata", rdata[k], 32'd0);
        end
        rst_n = 1'b1;

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < int'(DEPTH); i++)
                access(k, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

        // Write then read back with one wait state.
        access(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        // Zero wait states.
        access(0, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Error cases, each followed by a read of the word it would have hit.
        for (int k = 0; k < 2; k++) begin
            access(k, 1'b0, 1'b1, 32'h6, 32'h1111_1111, 1'b0);
            access(k, 1'b1, 1'b0, 32'(DEPTH * 4), 32'h0, 1'b0);
            access(k, 1'b0, 1'b1, 32'(DEPTH * 4), 32'h2222_2222, 1'b0);
            access(k, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h3333_3333, 1'b0);
            access(k, 1'b1, 1'b1, 32'h10, 32'h4444_4444, 1'b0);
            access(k, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
            access(k, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        end

        // Inputs toggled and cs held while busy: only the captured access lands.
        for (int k = 0; k < 2; k++) begin
            access(k, 1'b0, 1'b1, 32'h30, 32'hA5A5_5A5A, 1'b1);
            access(k, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
            access(k, 1'b1, 1'b0, 32'h34, 32'h0, 1'b0);
        end

        // Reset during the wait state of a write aborts it.
        access(1, 1'b0, 1'b1, 32'h20, 32'h0102_0304, 1'b0);
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        @(negedge clk);
        cs[1] = 1'b1; r[1] = 1'b0; w[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        cs[1] = 1'b0; w[1] = 1'b0;
        check("busy_in_wait", 32'(busy[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy[1]), 32'd0);
        check("rst_ready", 32'(ready[1]), 32'd0);
        check("rst_err", 32'(err[1]), 32'd0);
        check("rst_rdata", rdata[1], 32'd0);
        for (int k = 0; k < 2; k++) begin
            last_rd[k] = '0; n_rd[k] = 0; n_wr[k] = 0; n_er[k] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Mixed random traffic including misaligned, out-of-range and conflicting requests.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 24; i++) begin
                int          op;
                logic [31:0] a;
                op = int'($urandom_range(0, 9));
                a  = 32'($urandom_range(0, 17) * 4);
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                access(k, (op <= 4), (op == 0 || op >= 5), a, $urandom, 1'b0);
            end
        end

`ifdef DMEM_STATS_EN
        for (int k = 0; k < 2; k++) begin
            check("rd_count", 32'(rdc[k]), 32'(n_rd[k]));
            check("wr_count", 32'(wrc[k]), 32'(n_wr[k]));
            check("err_count", 32'(erc[k]), 32'(n_er[k]));
        end
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
